// File: rtl/osc_note_ctrl.sv
// Monophonic note controller for freq_gen: key/octave selection and
// wrap-aligned divider updates so no oscillator period is ever truncated.
module osc_note_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] keys,
  input  logic        oct_up,
  input  logic        oct_dn,
  input  logic [15:0] osc_count,
  output logic        osc_en,
  output logic [15:0] osc_divider,
  output logic [3:0]  note,
  output logic [1:0]  octave
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PEND
  } state_t;

  localparam logic [3:0] NONE = 4'd15;

  state_t      state;
  state_t      state_nx;
  logic [12:0] key_q;
  logic        up_q;
  logic        dn_q;
  logic [15:0] pend_div;
  logic [15:0] pend_nx;
  logic [15:0] div_nx;
  logic [3:0]  note_nx;
  logic [1:0]  oct_nx;
  logic [12:0] press;
  logic [12:0] rel;
  logic        up_e;
  logic        dn_e;
  logic        sel_rel;
  logic [3:0]  hi_press;
  logic [3:0]  lo_held;
  logic [15:0] target;
  logic        wrap;
  logic        none;

  function automatic logic [15:0] base_div(input logic [3:0] k);
    case (k)
      4'd0:    return 16'd38223;
      4'd1:    return 16'd36078;
      4'd2:    return 16'd34053;
      4'd3:    return 16'd32141;
      4'd4:    return 16'd30337;
      4'd5:    return 16'd28634;
      4'd6:    return 16'd27028;
      4'd7:    return 16'd25510;
      4'd8:    return 16'd24079;
      4'd9:    return 16'd22727;
      4'd10:   return 16'd21452;
      4'd11:   return 16'd20248;
      4'd12:   return 16'd19111;
      default: return 16'd0;
    endcase
  endfunction

  assign press = keys & ~key_q;
  assign rel   = ~keys & key_q;
  assign up_e  = oct_up & ~up_q;
  assign dn_e  = oct_dn & ~dn_q;
  assign wrap  = osc_count >= osc_divider;

  always_comb begin
    oct_nx = octave;
    if (up_e && !dn_e && octave != 2'd3)
      oct_nx = octave + 2'd1;
    else if (dn_e && !up_e && octave != 2'd0)
      oct_nx = octave - 2'd1;
  end

  always_comb begin
    hi_press = 4'd0;
    lo_held  = 4'd0;
    sel_rel  = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (press[i])
        hi_press = 4'(i);
      if (rel[i] && note == 4'(i))
        sel_rel = 1'b1;
    end
    for (int i = 12; i >= 0; i--) begin
      if (keys[i])
        lo_held = 4'(i);
    end
  end

  // A fresh press always wins; fallback only when the sounding key lifts.
  always_comb begin
    note_nx = note;
    if (|press)
      note_nx = hi_press;
    else if (sel_rel && |keys)
      note_nx = lo_held;
    else if (~|keys)
      note_nx = NONE;
  end

  assign none   = note_nx == NONE;
  assign target = base_div(note_nx) >> oct_nx;

  always_comb begin
    state_nx = state;
    div_nx   = osc_divider;
    pend_nx  = pend_div;
    unique case (state)
      IDLE: begin
        if (!none) begin
          state_nx = PLAY;
          div_nx   = target;
        end
      end
      PLAY: begin
        if (none) begin
          state_nx = IDLE;
        end else if (target != osc_divider) begin
          state_nx = PEND;
          pend_nx  = target;
        end
      end
      PEND: begin
        if (none) begin
          state_nx = IDLE;
          pend_nx  = 16'd0;
        end else if (target == osc_divider) begin
          state_nx = PLAY;
          pend_nx  = 16'd0;
        end else if (wrap) begin
          div_nx = pend_div;
          if (target != pend_div) begin
            pend_nx = target;
          end else begin
            state_nx = PLAY;
            pend_nx  = 16'd0;
          end
        end else begin
          pend_nx = target;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_q       <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      octave      <= 2'd0;
      note        <= NONE;
      osc_en      <= 1'b0;
      osc_divider <= 16'd0;
      pend_div    <= 16'd0;
    end else begin
      state       <= state_nx;
      key_q       <= keys;
      up_q        <= oct_up;
      dn_q        <= oct_dn;
      octave      <= oct_nx;
      note        <= note_nx;
      osc_en      <= state_nx != IDLE;
      osc_divider <= div_nx;
      pend_div    <= pend_nx;
    end
  end

endmodule

// File: tb/tb_osc_note_ctrl.sv
// Scoreboard bench for osc_note_ctrl: directed scenarios then random
// key/octave/count traffic against a behavioural note/divider model.
module tb_osc_note_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] keys;
  logic        oct_up;
  logic        oct_dn;
  logic [15:0] osc_count;
  logic        osc_en;
  logic [15:0] osc_divider;
  logic [3:0]  note;
  logic [1:0]  octave;

  osc_note_ctrl dut (
    .clk(clk),
    .rst(rst),
    .keys(keys),
    .oct_up(oct_up),
    .oct_dn(oct_dn),
    .osc_count(osc_count),
    .osc_en(osc_en),
    .osc_divider(osc_divider),
    .note(note),
    .octave(octave)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [15:0] div;
    logic [3:0]  note;
    logic [1:0]  oct;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int base[13] = '{38223, 36078, 34053, 32141, 30337, 28634, 27028,
                   25510, 24079, 22727, 21452, 20248, 19111};

  int          m_note;
  bit          m_play;
  int          m_div;
  int          m_pend;
  int          m_oct;
  logic [12:0] m_kq;
  bit          m_uq;
  bit          m_dq;

  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_note = -1; m_play = 0; m_div = 0; m_pend = -1;
      m_oct = 0; m_kq = '0; m_uq = 0; m_dq = 0;
    end else begin
      logic [12:0] pr;
      logic [12:0] rl;
      int hi;
      int lo;
      int tgt;
      bit up;
      bit dn;
      bit wr;
      pr = keys & ~m_kq;
      rl = ~keys & m_kq;
      hi = -1;
      lo = -1;
      for (int i = 0; i < 13; i++) if (pr[i]) hi = i;
      for (int i = 12; i >= 0; i--) if (keys[i]) lo = i;
      if (hi >= 0) m_note = hi;
      else if (m_note >= 0 && rl[m_note] && keys != 0) m_note = lo;
      else if (keys == 0) m_note = -1;
      up = oct_up && !m_uq;
      dn = oct_dn && !m_dq;
      if (up && !dn && m_oct < 3) m_oct++;
      else if (dn && !up && m_oct > 0) m_oct--;
      tgt = (m_note < 0) ? 0 : (base[m_note] >> m_oct);
      wr = int'(osc_count) >= m_div;
      if (!m_play) begin
        if (m_note >= 0) begin
          m_play = 1; m_div = tgt; m_pend = -1;
        end
      end else if (m_note < 0) begin
        m_play = 0; m_pend = -1;
      end else if (m_pend < 0) begin
        if (tgt != m_div) m_pend = tgt;
      end else if (tgt == m_div) begin
        m_pend = -1;
      end else if (wr) begin
        m_div = m_pend;
        m_pend = (tgt != m_div) ? tgt : -1;
      end else begin
        m_pend = tgt;
      end
      m_kq = keys; m_uq = oct_up; m_dq = oct_dn;
    end
    e.en   = m_play;
    e.div  = 16'(m_div);
    e.note = (m_note < 0) ? 4'd15 : 4'(m_note);
    e.oct  = 2'(m_oct);
    q.push_back(e);
  endtask

  task automatic step(input logic [12:0] k, input logic u, input logic d,
                      input logic [15:0] c, input logic r);
    @(negedge clk);
    keys = k; oct_up = u; oct_dn = d; osc_count = c; rst = r;
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic dchk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ({osc_en, osc_divider, note, octave} !== e) begin
        n_fail++;
        $display("FAIL scoreboard cyc %0d: got en=%0d div=%0d note=%0d oct=%0d expected en=%0d div=%0d note=%0d oct=%0d",
                 cyc, osc_en, osc_divider, note, octave, e.en, e.div, e.note, e.oct);
      end
    end
  end

  initial begin
    logic [12:0] k;
    logic        u;
    logic        d;
    logic [15:0] c;
    int          r;
    int          w;
    rst = 1'b1; keys = '0; oct_up = 1'b0; oct_dn = 1'b0; osc_count = '0;

    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);
    dchk("reset_en", osc_en, 0);
    dchk("reset_div", osc_divider, 0);
    dchk("reset_note", note, 15);
    dchk("reset_oct", octave, 0);

    step(13'h1 << 9, 0, 0, 0, 0);
    dchk("first_en", osc_en, 1);
    dchk("first_div", osc_divider, 22727);
    dchk("first_note", note, 9);

    step(13'h1 << 9, 0, 0, 50, 0);
    step((13'h1 << 9) | 13'h1, 0, 0, 100, 0);
    dchk("chg_note", note, 0);
    dchk("chg_div_hold", osc_divider, 22727);
    step((13'h1 << 9) | 13'h1, 0, 0, 22726, 0);
    dchk("chg_div_prewrap", osc_divider, 22727);
    step((13'h1 << 9) | 13'h1, 0, 0, 22727, 0);
    dchk("chg_div_wrap", osc_divider, 38223);

    step('0, 0, 0, 0, 0);
    step(13'h024, 0, 0, 0, 0);
    step(13'h024, 0, 0, 0, 0);
    step(13'h8a4, 0, 0, 0, 0);
    dchk("prio_note", note, 11);
    step(13'h0a4, 0, 0, 0, 0);
    dchk("fallback_note", note, 2);
    dchk("fallback_div_hold", osc_divider, 28634);
    step(13'h0a4, 0, 0, 28634, 0);
    dchk("fallback_div_wrap", osc_divider, 34053);

    step('0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step('0, 1, 0, 0, 0);
      step('0, 0, 0, 0, 0);
    end
    dchk("oct_sat", octave, 3);
    step(13'h1 << 12, 0, 0, 0, 0);
    dchk("oct3_div", osc_divider, 2388);
    step(13'h1 << 12, 1, 1, 0, 0);
    dchk("oct_both", octave, 3);
    step(13'h1 << 12, 0, 0, 0, 0);
    step(13'h1 << 12, 0, 1, 0, 0);
    dchk("pend_oct", octave, 2);
    dchk("pend_div_hold", osc_divider, 2388);
    step('0, 0, 0, 0, 0);
    dchk("off_en", osc_en, 0);
    dchk("off_div", osc_divider, 2388);
    dchk("off_note", note, 15);

    step(13'h1 << 3, 0, 0, 0, 0);
    step(13'h3 << 3, 0, 0, 0, 0);
    step(13'h3 << 3, 0, 0, 0, 1);
    dchk("rst_pend_en", osc_en, 0);
    dchk("rst_pend_div", osc_divider, 0);
    dchk("rst_pend_oct", octave, 0);

    k = '0; u = 0; d = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 15);
      if (r < 5) k[$urandom_range(0, 12)] ^= 1'b1;
      else if (r == 5) k = '0;
      if ($urandom_range(0, 7) == 0) u = ~u;
      if ($urandom_range(0, 7) == 0) d = ~d;
      r = $urandom_range(0, 5);
      if (r == 0) c = 16'(m_div);
      else if (r == 1) c = 16'hffff;
      else c = 16'($urandom_range(0, 999));
      step(k, u, d, c, $urandom_range(0, 299) == 0);
    end

    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
